// File: rtl/pulse_gen_arbiter.sv
// pulse_gen_arbiter: shares one pulse generator between N_REQ requesters.
// A round-robin arbiter picks one request at a time. The sequencer then drives
// gen_start, follows gen_pulse through its rising and falling edges, and pulses
// ack to the served requester. Nothing runs until the generator reports ready.
// A watchdog bounds the time from the end of start to the rise of the pulse.
//
// Optional feature: define PULSE_ARB_GAP_EN to insert GAP_CYCLES idle cycles
// after every completed or timed-out pulse. When the macro is not defined,
// the GAP state does not exist and GAP_CYCLES has no effect on behaviour.

module pulse_gen_arbiter #(
  parameter int N_REQ          = 4,
  parameter int START_LEN      = 2,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int GAP_CYCLES     = 4,
  localparam int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  input  logic             gen_ready,
  output logic             gen_start,
  input  logic             gen_pulse,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic             err,
  output logic [ID_W-1:0]  err_id
);

  // One counter times START, WAIT_HIGH and GAP. It is sized for the longest
  // of those intervals so that it can hold every terminal value.
  localparam int CNT_MAX_A = (START_LEN > TIMEOUT_CYCLES) ? START_LEN : TIMEOUT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_LEN - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
`ifdef PULSE_ARB_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    ST_WAIT_READY = 3'd0,
    ST_IDLE       = 3'd1,
    ST_START      = 3'd2,
    ST_WAIT_HIGH  = 3'd3,
    ST_WAIT_LOW   = 3'd4,
    ST_DONE       = 3'd5
`ifdef PULSE_ARB_GAP_EN
    , ST_GAP      = 3'd6
`endif
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ID_W-1:0]   rr_last_q;
  logic              rose_q;
  logic [N_REQ-1:0]  ack_q;
  logic              gen_start_q;
  logic [ID_W-1:0]   grant_id_q;
  logic              busy_q;
  logic              err_q;
  logic [ID_W-1:0]   err_id_q;

  // Arbitration result for the current cycle.
  logic              arb_hit_d;
  logic [ID_W-1:0]   arb_idx_d;

  // One-hot vector with the given requester index set.
  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin pick: first set request after rr_last_q, wrapping modulo N_REQ.
  // The search runs from the farthest candidate towards the nearest one, so the
  // last hit, which is the nearest to rr_last_q, is the one that wins.
  always_comb begin
    arb_hit_d = 1'b0;
    arb_idx_d = rr_last_q;
    for (int i = N_REQ; i >= 1; i--) begin
      int cand;
      cand = int'(rr_last_q) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end else begin
        cand = cand;
      end
      if (req[cand]) begin
        arb_hit_d = 1'b1;
        arb_idx_d = ID_W'(cand);
      end else begin
        arb_hit_d = arb_hit_d;
      end
    end
  end

  // Sequencer FSM. All outputs are registered in this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WAIT_READY;
      cnt_q       <= '0;
      rr_last_q   <= ID_W'(N_REQ - 1);
      rose_q      <= 1'b0;
      ack_q       <= '0;
      gen_start_q <= 1'b0;
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      err_id_q    <= '0;
    end else begin
      // ack and err are single-cycle pulses.
      ack_q <= '0;
      err_q <= 1'b0;

      if (!gen_ready && (state_q != ST_WAIT_READY)) begin
        // Generator lost: abandon any pulse in flight. An error is reported only
        // if a pulse was being sequenced; DONE and GAP abort silently.
        if (busy_q) begin
          err_q    <= 1'b1;
          err_id_q <= grant_id_q;
        end
        state_q     <= ST_WAIT_READY;
        gen_start_q <= 1'b0;
        busy_q      <= 1'b0;
        cnt_q       <= '0;
        rose_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_WAIT_READY: begin
            if (gen_ready) begin
              state_q <= ST_IDLE;
            end
          end

          ST_IDLE: begin
            if (arb_hit_d) begin
              grant_id_q  <= arb_idx_d;
              rr_last_q   <= arb_idx_d;
              state_q     <= ST_START;
              gen_start_q <= 1'b1;
              busy_q      <= 1'b1;
              cnt_q       <= '0;
              rose_q      <= 1'b0;
            end
          end

          ST_START: begin
            // Remember a pulse that rises while start is still held high.
            if (gen_pulse) begin
              rose_q <= 1'b1;
            end
            if (cnt_q == START_LAST) begin
              gen_start_q <= 1'b0;
              cnt_q       <= '0;
              if (rose_q || gen_pulse) begin
                state_q <= ST_WAIT_LOW;
              end else begin
                state_q <= ST_WAIT_HIGH;
              end
            end else begin
              cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end

          ST_WAIT_HIGH: begin
            if (gen_pulse) begin
              state_q <= ST_WAIT_LOW;
            end else if (cnt_q >= TIMEOUT_LAST) begin
              // Watchdog expired: report against this grant and drop it.
              err_q    <= 1'b1;
              err_id_q <= grant_id_q;
              busy_q   <= 1'b0;
              cnt_q    <= '0;
`ifdef PULSE_ARB_GAP_EN
              state_q  <= ST_GAP;
`else
              state_q  <= ST_IDLE;
`endif
            end else if (cnt_q != CNT_SAT) begin
              cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end

          ST_WAIT_LOW: begin
            // The generator owns the pulse width, so there is no watchdog here.
            if (!gen_pulse) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
            end
          end

          ST_DONE: begin
            ack_q <= onehot(grant_id_q);
            cnt_q <= '0;
`ifdef PULSE_ARB_GAP_EN
            state_q <= ST_GAP;
`else
            state_q <= ST_IDLE;
`endif
          end

`ifdef PULSE_ARB_GAP_EN
          ST_GAP: begin
            // Enforced idle time between pulses; new requests wait here.
            if (cnt_q == GAP_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
`endif

          default: begin
            state_q     <= ST_WAIT_READY;
            gen_start_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            rose_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ack       = ack_q;
  assign gen_start = gen_start_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign err_id    = err_id_q;

endmodule

// File: tb/tb_pulse_gen_arbiter.sv
// Directed testbench for pulse_gen_arbiter (N_REQ=4, START_LEN=2,
// TIMEOUT_CYCLES=32, GAP_CYCLES=4). The generator model raises its pulse
// 3 cycles after start rises and holds it for 5 cycles.

module tb_pulse_gen_arbiter;

  localparam int N = 4;
`ifdef PULSE_ARB_GAP_EN
  localparam int GAP_EXP = 5;
`else
  localparam int GAP_EXP = 1;
`endif

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] ack;
  logic         gen_ready;
  logic         gen_start;
  logic         gen_pulse;
  logic [1:0]   grant_id;
  logic         busy;
  logic         err;
  logic [1:0]   err_id;

  int checks = 0;
  int errors = 0;

  // Generator model control: 0 = normal pulse, 1 = never raise the pulse.
  int gen_mode = 0;

  // Monitor counters.
  int start_cnt = 0;
  int err_cnt = 0;
  int ack_cnt [N];
  int overlap_viol = 0;
  int ack_wide_viol = 0;
  int last_start_len = 0;
  int cur_len = 0;

  pulse_gen_arbiter #(
    .N_REQ(4),
    .START_LEN(2),
    .TIMEOUT_CYCLES(32),
    .GAP_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .ack(ack),
    .gen_ready(gen_ready),
    .gen_start(gen_start),
    .gen_pulse(gen_pulse),
    .grant_id(grant_id),
    .busy(busy),
    .err(err),
    .err_id(err_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Generator model: rise 3 cycles after start, width 5 cycles.
  initial begin
    gen_pulse = 1'b0;
    forever begin
      @(posedge gen_start);
      if (gen_mode == 0) begin
        repeat (3) @(posedge clk);
        #1 gen_pulse = 1'b1;
        repeat (5) @(posedge clk);
        #1 gen_pulse = 1'b0;
      end
    end
  end

  // Monitor: reads outputs at the clock edge (values of the previous cycle).
  initial begin
    logic gs_prev;
    logic busy_prev;
    logic [N-1:0] ack_prev;
    gs_prev = 1'b0;
    busy_prev = 1'b0;
    ack_prev = '0;
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    forever begin
      @(posedge clk);
      if (gen_start === 1'b1 && !gs_prev) begin
        start_cnt++;
        if (busy_prev) overlap_viol++;
        cur_len = 0;
      end
      if (gen_start === 1'b1) cur_len++;
      else if (gs_prev) last_start_len = cur_len;
      if (ack != '0 && ack_prev != '0) ack_wide_viol++;
      for (int i = 0; i < N; i++) if (ack[i] === 1'b1) ack_cnt[i]++;
      if (err === 1'b1) err_cnt++;
      gs_prev = (gen_start === 1'b1);
      busy_prev = (busy === 1'b1);
      ack_prev = ack;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_ack(input int bound);
    int n;
    n = 0;
    while (ack == '0 && n < bound) begin
      tick;
      n++;
    end
  endtask

  task automatic wait_start(input int bound);
    int n;
    n = 0;
    while (gen_start !== 1'b1 && n < bound) begin
      tick;
      n++;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    gen_ready = 1'b0;
    req = '0;
    gen_mode = 0;
    tick;
    tick;
    reset = 1'b0;
    tick;
  endtask

  initial begin
    int exp_grant [5];
    logic [N-1:0] exp_ack;
    int base_ack;
    int base_err;
    int base_start;
    int n;

    reset = 1'b0;
    gen_ready = 1'b0;
    req = '0;
    #2 reset = 1'b1;
    tick;
    tick;

    // ---- Reset values
    check("rst_gen_start", gen_start, 1'b0);
    check("rst_ack", ack, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_err_id", err_id, 2'd0);

    // ---- Test 1: single request, gen_ready 10 cycles after reset
    reset = 1'b0;
    req = 4'b0001;
    repeat (10) tick;
    check("t1_no_start_before_ready", start_cnt, 0);
    check("t1_gen_start_low", gen_start, 1'b0);
    gen_ready = 1'b1;
    tick;
    check("t1_idle_gen_start", gen_start, 1'b0);
    tick;
    check("t1_start_1", gen_start, 1'b1);
    check("t1_busy_start", busy, 1'b1);
    check("t1_grant_id", grant_id, 2'd0);
    tick;
    check("t1_start_2", gen_start, 1'b1);
    tick;
    check("t1_start_end", gen_start, 1'b0);
    check("t1_busy_wait", busy, 1'b1);
    repeat (7) tick;
    check("t1_ack_not_yet", ack, 4'b0000);
    tick;
    check("t1_ack", ack, 4'b0001);
    check("t1_err", err, 1'b0);
    req = 4'b0000;
    tick;
    check("t1_ack_one_cycle", ack, 4'b0000);
    check("t1_start_len", last_start_len, 2);
    check("t1_ack_count", ack_cnt[0], 1);
    check("t1_err_count", err_cnt, 0);

    // ---- Test 2: all requesters, round-robin order from reset
    do_reset;
    exp_grant[0] = 0; exp_grant[1] = 1; exp_grant[2] = 2; exp_grant[3] = 3; exp_grant[4] = 0;
    req = 4'b1111;
    gen_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(100);
      check("t2_ack_seen", (ack != 4'b0000), 1'b1);
      exp_ack = 4'b0001 << exp_grant[k];
      check("t2_ack_onehot", ack, exp_ack);
      check("t2_grant_id", grant_id, exp_grant[k]);
      if (k == 4) req = 4'b0000;
      tick;
      check("t2_ack_one_cycle", ack, 4'b0000);
    end
    tick;
    check("t2_no_overlap", overlap_viol, 0);
    check("t2_ack_width", ack_wide_viol, 0);

    // ---- Test 3: watchdog timeout on grant 2
    base_ack = ack_cnt[2];
    gen_mode = 1;
    req = 4'b0100;
    wait_start(20);
    check("t3_start_seen", gen_start, 1'b1);
    check("t3_grant_id", grant_id, 2'd2);
    repeat (33) tick;
    check("t3_no_early_err", err, 1'b0);
    check("t3_busy_before_to", busy, 1'b1);
    tick;
    check("t3_err", err, 1'b1);
    check("t3_err_id", err_id, 2'd2);
    check("t3_busy_after_to", busy, 1'b0);
    gen_mode = 0;
    tick;
    check("t3_err_one_cycle", err, 1'b0);
    check("t3_no_ack", ack_cnt[2], base_ack);
    wait_ack(100);
    check("t3_ack_seen", (ack != 4'b0000), 1'b1);
    check("t3_ack_after", ack, 4'b0100);
    req = 4'b0000;
    tick;

    // ---- Test 4: gen_ready loss during WAIT_LOW of grant 1
    base_ack = ack_cnt[1];
    req = 4'b0010;
    wait_start(20);
    check("t4_start_seen", gen_start, 1'b1);
    check("t4_grant_id", grant_id, 2'd1);
    repeat (4) tick;
    check("t4_busy_wait_low", busy, 1'b1);
    base_start = start_cnt;
    gen_ready = 1'b0;
    tick;
    check("t4_err", err, 1'b1);
    check("t4_err_id", err_id, 2'd1);
    check("t4_busy_abort", busy, 1'b0);
    check("t4_start_abort", gen_start, 1'b0);
    repeat (4) tick;
    check("t4_no_start_while_lost", start_cnt, base_start);
    check("t4_no_ack", ack_cnt[1], base_ack);
    gen_ready = 1'b1;
    wait_ack(100);
    check("t4_ack_seen", (ack != 4'b0000), 1'b1);
    check("t4_ack_after", ack, 4'b0010);
    check("t4_grant_after", grant_id, 2'd1);
    req = 4'b0000;
    tick;

    // ---- Test 5: asynchronous reset in the middle of START
    base_err = err_cnt;
    req = 4'b0001;
    wait_start(20);
    check("t5_start_seen", gen_start, 1'b1);
    #2 reset = 1'b1;
    gen_ready = 1'b0;
    req = 4'b0000;
    #1;
    check("t5_async_gen_start", gen_start, 1'b0);
    check("t5_async_busy", busy, 1'b0);
    check("t5_async_ack", ack, 4'b0000);
    check("t5_async_grant", grant_id, 2'd0);
    tick;
    reset = 1'b0;
    repeat (10) tick;
    check("t5_wait_ready_start", gen_start, 1'b0);
    check("t5_wait_ready_busy", busy, 1'b0);
    req = 4'b1111;
    gen_ready = 1'b1;
    wait_start(20);
    check("t5_start_after", gen_start, 1'b1);
    check("t5_first_grant", grant_id, 2'd0);
    wait_ack(100);
    check("t5_ack", ack, 4'b0001);
    req = 4'b0000;
    tick;
    check("t5_no_err", err_cnt, base_err);

    // ---- Test 6: spacing between ack and the next start
    do_reset;
    req = 4'b0011;
    gen_ready = 1'b1;
    wait_ack(100);
    check("t6_ack0", ack, 4'b0001);
    check("t6_busy_at_ack", busy, 1'b0);
    req = 4'b0010;
    n = 0;
    do begin
      tick;
      n++;
    end while (gen_start !== 1'b1 && n < 20);
    check("t6_gap", n, GAP_EXP);
    check("t6_grant1", grant_id, 2'd1);
    wait_ack(100);
    check("t6_ack1", ack, 4'b0010);
    req = 4'b0000;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
